// File: rtl/mux_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_bus_arbiter_if
//
// Purpose: bundles the requester handshake, requester data and the arbitrated
// output bus of the two-requester mux arbiter into one interface.
//
// Signals:
//   req_a, req_b     requester has a beat to send this cycle
//   data_a, data_b   requester data (WIDTH bits)
//   gnt_a, gnt_b     requester currently owns the shared datapath
//   sel              mux select driven by the arbiter (0 = A, 1 = B)
//   out_data         registered selected data (WIDTH bits)
//   out_valid        out_data holds a beat accepted on the previous cycle
//   busy             arbiter is in a grant state
//
// Modports:
//   master  requester side (drives requests and data, observes grants/output)
//   slave   arbiter side   (observes requests and data, drives grants/output)
// ---------------------------------------------------------------------------
interface mux_bus_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;

    modport master (
        output req_a,
        output req_b,
        output data_a,
        output data_b,
        input  gnt_a,
        input  gnt_b,
        input  sel,
        input  out_data,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  req_a,
        input  req_b,
        input  data_a,
        input  data_b,
        output gnt_a,
        output gnt_b,
        output sel,
        output out_data,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mux_bus_arbiter
//
// Purpose: arbitrates two requesters (A and B) onto one shared 2:1 mux
// datapath. Grants are round-robin between the requesters and each grant is
// limited to BURST accepted beats. The arbiter owns the mux select and
// registers the selected beat onto the output bus with a valid strobe.
//
// Ports:
//   clk    single rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mux_bus_arbiter_if.slave
//            in : req_a, req_b, data_a, data_b
//            out: gnt_a, gnt_b, sel, out_data, out_valid, busy
//
// Parameters:
//   WIDTH  data width of each requester bus and of the output bus
//   BURST  maximum beats per grant (1..15)
//   CNT_W  width of the beat counter (must hold BURST-1)
//
// Build option:
//   FIXED_PRIO_EN  when defined, ties always go to A (last-served history is
//                  ignored); B is still served whenever A is not requesting
//                  and burst limits still apply.
// ---------------------------------------------------------------------------
module mux_bus_arbiter #(
    parameter int WIDTH = 4,
    parameter int BURST = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // 1 when B was the last requester whose grant ended; resets to B so that
    // A wins the first tie after reset.
    logic             last_b_q, last_b_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    // Request of the current owner and the shared 2:1 mux output.
    logic             own_req;
    logic [WIDTH-1:0] mux_data;
    logic             grant_end;
    logic             sel_int;

    // -----------------------------------------------------------------------
    // Arbitration helpers
    // -----------------------------------------------------------------------

    // Winner when both requesters arrive together from IDLE.
    function automatic state_t tie_pick(input logic last_b);
`ifdef FIXED_PRIO_EN
        tie_pick = GRANT_A;
`else
        tie_pick = last_b ? GRANT_A : GRANT_B;
`endif
    endfunction

    // Next owner when the current grant ends. The other requester takes over
    // directly (no IDLE bubble); otherwise the current owner re-enters with a
    // fresh burst if it is still requesting.
    function automatic state_t end_pick(input state_t cur,
                                        input logic   ra,
                                        input logic   rb);
`ifdef FIXED_PRIO_EN
        if (ra)
            end_pick = GRANT_A;
        else if (rb)
            end_pick = GRANT_B;
        else
            end_pick = IDLE;
`else
        if (cur == GRANT_A) begin
            if (rb)
                end_pick = GRANT_B;
            else if (ra)
                end_pick = GRANT_A;
            else
                end_pick = IDLE;
        end else begin
            if (ra)
                end_pick = GRANT_A;
            else if (rb)
                end_pick = GRANT_B;
            else
                end_pick = IDLE;
        end
`endif
    endfunction

    // -----------------------------------------------------------------------
    // Shared datapath select
    // -----------------------------------------------------------------------
    assign sel_int  = (state_q == GRANT_B);
    assign mux_data = sel_int ? bus.data_b : bus.data_a;

    always_comb begin
        own_req = 1'b0;
        case (state_q)
            GRANT_A: own_req = bus.req_a;
            GRANT_B: own_req = bus.req_b;
            default: own_req = 1'b0;
        endcase
    end

    // A grant ends either when the owner drops its request or when the
    // beat being accepted now is the last one of the burst.
    assign grant_end = !own_req || (cnt_q == BEAT_LAST);

    // -----------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state, beat counter and accept path
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_a && bus.req_b)
                    state_d = tie_pick(last_b_q);
                else if (bus.req_a)
                    state_d = GRANT_A;
                else if (bus.req_b)
                    state_d = GRANT_B;
                else
                    state_d = IDLE;
            end

            GRANT_A, GRANT_B: begin
                // Accept cycle: the owner's beat is captured from the mux.
                if (own_req) begin
                    out_data_d  = mux_data;
                    out_valid_d = 1'b1;
                end

                if (grant_end) begin
                    cnt_d    = '0;
                    last_b_d = (state_q == GRANT_B);
                    state_d  = end_pick(state_q, bus.req_a, bus.req_b);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: Moore outputs decoded from state only
    // -----------------------------------------------------------------------
    always_comb begin
        bus.gnt_a = 1'b0;
        bus.gnt_b = 1'b0;
        bus.sel   = 1'b0;
        bus.busy  = 1'b0;
        case (state_q)
            GRANT_A: begin
                bus.gnt_a = 1'b1;
                bus.busy  = 1'b1;
            end
            GRANT_B: begin
                bus.gnt_b = 1'b1;
                bus.sel   = 1'b1;
                bus.busy  = 1'b1;
            end
            default: begin
                bus.gnt_a = 1'b0;
                bus.gnt_b = 1'b0;
                bus.sel   = 1'b0;
                bus.busy  = 1'b0;
            end
        endcase
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_bus_arbiter
//
// Directed and randomized stimulus for mux_bus_arbiter, compared each cycle
// against a behavioural model expressed as "who owns the bus, how many beats
// it has used, who was served last".
// ---------------------------------------------------------------------------
module tb_mux_bus_arbiter;

    localparam int WIDTH = 4;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mux_bus_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_bus_arbiter #(
        .WIDTH (WIDTH),
        .BURST (BURST),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model state: owner 0 = nobody, 1 = A, 2 = B.
    int         m_owner;
    int         m_used;
    int         m_last;
    logic [3:0] m_out;
    logic       m_vld;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic model_reset();
        m_owner = 0;
        m_used  = 0;
        m_last  = 2;
        m_out   = 4'h0;
        m_vld   = 1'b0;
    endtask

    function automatic int pick_tie(input int last);
`ifdef FIXED_PRIO_EN
        return 1;
`else
        return (last == 1) ? 2 : 1;
`endif
    endfunction

    function automatic int pick_after(input int x, input logic ra, input logic rb);
`ifdef FIXED_PRIO_EN
        if (ra) return 1;
        if (rb) return 2;
        return 0;
`else
        int   other;
        logic ro, rx;
        other = 3 - x;
        ro    = (other == 1) ? ra : rb;
        rx    = (x == 1) ? ra : rb;
        if (ro) return other;
        if (rx) return x;
        return 0;
`endif
    endfunction

    task automatic model_step(input logic ra, input logic rb,
                              input logic [3:0] da, input logic [3:0] db);
        int   x;
        logic rx;
        if (m_owner == 0) begin
            m_vld = 1'b0;
            if (ra && rb)  m_owner = pick_tie(m_last);
            else if (ra)   m_owner = 1;
            else if (rb)   m_owner = 2;
        end else begin
            x  = m_owner;
            rx = (x == 1) ? ra : rb;
            if (rx) begin
                m_out  = (x == 1) ? da : db;
                m_vld  = 1'b1;
                m_used = m_used + 1;
            end else begin
                m_vld = 1'b0;
            end
            if (!rx || m_used == BURST) begin
                m_last  = x;
                m_used  = 0;
                m_owner = pick_after(x, ra, rb);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [8:0] obs, exp;
        exp = {(m_owner == 1), (m_owner == 2), (m_owner == 2), (m_owner != 0), m_vld, m_out};
        obs = {bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.out_valid, bus.out_data};
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: {gnt_a,gnt_b,sel,busy,valid,data} observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    // One clock: check the outputs of the current cycle, drive this cycle's
    // inputs, then advance the model across the rising edge.
    task automatic cyc(input string tag, input logic ra, input logic rb,
                       input logic [3:0] da, input logic [3:0] db);
        @(negedge clk);
        check_outputs(tag);
        bus.req_a  = ra;
        bus.req_b  = rb;
        bus.data_a = da;
        bus.data_b = db;
        @(posedge clk);
        model_step(ra, rb, da, db);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset      = 1'b1;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 4'h0;
        bus.data_b = 4'h0;
        model_reset();
        repeat (n) begin
            @(negedge clk);
            check_outputs("reset_hold");
        end
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 4'h0;
        bus.data_b = 4'h0;
        model_reset();

        // Reset held, then idle with no requests.
        do_reset(3);
        for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 1'b0, 4'h0, 4'h0);

        // A alone, data 1..5: burst of 4, then a fresh grant.
        cyc("a_req", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 1; i <= 5; i++) cyc("a_burst", 1'b1, 1'b0, 4'(i), 4'h0);
        for (int i = 0; i < 3; i++) cyc("a_drain", 1'b0, 1'b0, 4'h0, 4'h0);

        // Both requesting from reset: A first, then B without a gap.
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc("tie", 1'b1, 1'b1, 4'hA, 4'hB);
        cyc("tie_end", 1'b0, 1'b0, 4'h0, 4'h0);

        // B granted, drops after 2 beats while A requests.
        do_reset(1);
        cyc("b_req", 1'b0, 1'b1, 4'h0, 4'h0);
        cyc("b_beat1", 1'b1, 1'b1, 4'h3, 4'h1);
        cyc("b_beat2", 1'b1, 1'b1, 4'h4, 4'h2);
        cyc("b_drop", 1'b1, 1'b0, 4'h5, 4'h9);
        for (int i = 0; i < 3; i++) cyc("a_after_b", 1'b1, 1'b0, 4'(6 + i), 4'h0);
        cyc("b_drop_end", 1'b0, 1'b0, 4'h0, 4'h0);

        // Asynchronous reset during beat 3 of a B burst.
        do_reset(1);
        cyc("b5_req", 1'b0, 1'b1, 4'h0, 4'h0);
        cyc("b5_beat1", 1'b0, 1'b1, 4'h0, 4'h1);
        cyc("b5_beat2", 1'b0, 1'b1, 4'h0, 4'h2);
        @(negedge clk);
        check_outputs("b5_beat3");
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_b = 4'h3;
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs("mid_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) cyc("post_reset", 1'b1, 1'b1, 4'hC, 4'hD);

        // Both requesting continuously over several bursts.
        for (int i = 0; i < 12; i++) cyc("both_cont", 1'b1, 1'b1, 4'(i), 4'(15 - i));

        // Randomized traffic, requests biased high so bursts run to the limit.
        for (int i = 0; i < 400; i++) begin
            cyc("random",
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        check_outputs("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
